iomem_host_bridge: RTL and testbench
====================================

IOMEM_HOST_BRIDGE -- requirements
Module: iomem_host_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning bus cycles waited for iomem_ready before abort (1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have ports rx_data input 8, rx_valid input 1, rx_ready output 1: command byte stream in.
REQ-005 SHALL have ports tx_data output 8, tx_valid output 1, tx_ready input 1: response byte stream out.
REQ-006 SHALL have ports iomem_valid output 1, iomem_ready input 1, iomem_wstrb output 4, iomem_addr output 32, iomem_wdata output 32, iomem_rdata input 32: iomem initiator.
REQ-007 SHALL have port busy, output 1, high whenever state is not IDLE.

Function
REQ-008 SHALL accept a byte only on a cycle where rx_valid and rx_ready are both high; same rule for tx_valid/tx_ready.
REQ-009 SHALL implement states IDLE, ADDR, DATA, BUS, STAT, RDAT.
REQ-010 IDLE: rx_ready=1; accepted byte is CMD: bit7 = write, bits3:0 = wstrb, bits6:4 ignored; goes to ADDR.
REQ-011 ADDR: rx_ready=1; accepts 4 bytes MSB first into address; then DATA if write, else BUS.
REQ-012 DATA: rx_ready=1; accepts 4 bytes MSB first into wdata; then BUS.
REQ-013 SHALL hold rx_ready low in BUS, STAT, RDAT.
REQ-014 Write CMD with wstrb==0 SHALL skip BUS (no iomem_valid) and return status 0x01 only.
REQ-015 iomem_valid SHALL rise on the cycle after the final command byte is accepted.
REQ-016 During BUS, iomem_addr = {address[31:2],2'b00}, iomem_wdata = received data, iomem_wstrb = CMD[3:0] for write, 4'b0000 for read; all stable while iomem_valid is high.
REQ-017 SHALL sample iomem_ready only while iomem_valid is high; on ready, capture iomem_rdata, deassert iomem_valid next cycle, go to STAT with status 0x00.
REQ-018 STAT: tx_valid=1, tx_data=status, held stable until accepted; then RDAT if read and status 0x00, else IDLE.
REQ-019 RDAT: emits 4 captured rdata bytes MSB first, each held until accepted; then IDLE.
REQ-020 Outside STAT/RDAT, tx_valid SHALL be 0; outside BUS, iomem_valid SHALL be 0.
REQ-021 Next command SHALL be accepted no earlier than the cycle after the final response byte is accepted.
REQ-022 Back-to-back bytes (rx_valid held high) SHALL be accepted one per cycle with no bubbles.

Reset
REQ-023 On reset: state IDLE, rx_ready=1, tx_valid=0, tx_data=0, iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0, busy=0, timeout counter=0.
REQ-024 Reset asserted mid-command or mid-bus-cycle SHALL drop iomem_valid/tx_valid at that edge and discard the partial command; a late iomem_ready SHALL be ignored.

Configuration
REQ-025 Macro IOMEM_BRIDGE_TIMEOUT_EN SHALL select timeout logic.
REQ-026 With it defined: counter increments each BUS cycle without iomem_ready; on reaching TIMEOUT_CYCLES, iomem_valid drops next cycle, status 0xEE, no RDAT bytes.
REQ-027 Ready on the same cycle the counter reaches TIMEOUT_CYCLES SHALL complete normally (status 0x00).
REQ-028 Without it: no counter; BUS waits indefinitely; status is only 0x00 or 0x01.

Verification
REQ-029 Write: bytes 0x8F,03,00,00,00,DE,AD,BE,EF; responder ready after 1 cycle -> one iomem cycle addr 0x03000000, wdata 0xDEADBEEF, wstrb 0xF; tx 0x00.
REQ-030 Read: bytes 0x00,03,00,00,06, responder returns 0x12345678 -> iomem addr 0x03000004, wstrb 0; tx 0x00,12,34,56,78.
REQ-031 Write 0x80 + 8 bytes -> no iomem_valid ever; tx 0x01 only.
REQ-032 Timeout (macro on, TIMEOUT_CYCLES=4): read, ready never -> iomem_valid high exactly 4+1 cycles; tx 0xEE only; repeat with ready on the 4th wait cycle -> tx 0x00 + data.
REQ-033 Backpressure: tx_ready low 10 cycles during RDAT -> tx_data stable, no byte lost or duplicated; rx_valid high meanwhile -> no byte accepted.
REQ-034 Reset pulse in BUS with ready held low -> iomem_valid 0 at that edge; a following read completes normally.

Source files
------------

// File: rtl/iomem_host_bridge.sv
`timescale 1ns/1ps
// iomem_host_bridge: byte-stream command interface to a 32-bit iomem initiator.
// Command: CMD byte (bit7 = write, bits3:0 = wstrb), 4 address bytes MSB first,
// then 4 data bytes MSB first for writes. Response: one status byte, followed by
// 4 read-data bytes MSB first for a successful read.
// Optional feature: define IOMEM_BRIDGE_TIMEOUT_EN to abort a bus cycle after
// TIMEOUT_CYCLES cycles without iomem_ready (status 0xEE).
module iomem_host_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_STAT = 3'd4;
    localparam logic [2:0] S_RDAT = 3'd5;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_NOSTRB = 8'h01;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] ST_TMO    = 8'hEE;
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
`endif

    logic [2:0]  state_q,  state_d;
    logic        write_q,  write_d;
    logic [3:0]  strb_q,   strb_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wdata_q,  wdata_d;
    logic [31:0] rdata_q,  rdata_d;
    logic [1:0]  idx_q,    idx_d;
    logic [7:0]  status_q, status_d;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
    logic [15:0] tmo_q,    tmo_d;
`else
    logic [15:0] unused_tmo_cfg;
    assign unused_tmo_cfg = 16'(TIMEOUT_CYCLES);
`endif

    logic rx_fire;
    logic tx_fire;

    // Handshake-visible outputs decoded from the current state
    always_comb begin
        rx_ready    = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
        tx_valid    = (state_q == S_STAT) || (state_q == S_RDAT);
        iomem_valid = (state_q == S_BUS);
        busy        = (state_q != S_IDLE);
        iomem_addr  = {addr_q[31:2], 2'b00};
        iomem_wdata = wdata_q;
        iomem_wstrb = (iomem_valid && write_q) ? strb_q : 4'b0000;
        rx_fire     = rx_valid && rx_ready;
        tx_fire     = tx_valid && tx_ready;
        tx_data     = 8'h00;
        if (state_q == S_STAT) begin
            tx_data = status_q;
        end else if (state_q == S_RDAT) begin
            case (idx_q)
                2'd0:    tx_data = rdata_q[31:24];
                2'd1:    tx_data = rdata_q[23:16];
                2'd2:    tx_data = rdata_q[15:8];
                default: tx_data = rdata_q[7:0];
            endcase
        end
    end

    // Command parsing, bus cycle and response sequencing
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        strb_d   = strb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        idx_d    = idx_q;
        status_d = status_q;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
        tmo_d    = '0;
`endif
        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    write_d = rx_data[7];
                    strb_d  = rx_data[3:0];
                    idx_d   = 2'd0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_fire) begin
                    addr_d = {addr_q[23:0], rx_data};
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = write_q ? S_DATA : S_BUS;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_DATA: begin
                if (rx_fire) begin
                    wdata_d = {wdata_q[23:0], rx_data};
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        // A write with no byte lanes enabled never touches the bus
                        if (strb_q == 4'b0000) begin
                            status_d = ST_NOSTRB;
                            state_d  = S_STAT;
                        end else begin
                            state_d = S_BUS;
                        end
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_BUS: begin
                if (iomem_ready) begin
                    rdata_d  = iomem_rdata;
                    status_d = ST_OK;
                    state_d  = S_STAT;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
                end else if (tmo_q == TMO_LIMIT) begin
                    status_d = ST_TMO;
                    state_d  = S_STAT;
                end else begin
                    tmo_d = tmo_q + 16'd1;
`endif
                end
            end
            S_STAT: begin
                if (tx_fire) begin
                    idx_d   = 2'd0;
                    state_d = (!write_q && status_q == ST_OK) ? S_RDAT : S_IDLE;
                end
            end
            S_RDAT: begin
                if (tx_fire) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            strb_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            idx_q    <= '0;
            status_q <= '0;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            strb_q   <= strb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            idx_q    <= idx_d;
            status_q <= status_d;
`ifdef IOMEM_BRIDGE_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_iomem_host_bridge.sv
`timescale 1ns/1ps
// Directed bench for iomem_host_bridge: drives command byte streams, models an
// iomem responder with programmable latency, logs response bytes and bus cycles.
module tb_iomem_host_bridge;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    iomem_host_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy        (busy)
    );

    // responder controls (driven by stimulus)
    logic        resp_never = 1'b0;
    int          resp_lat   = 0;
    logic [31:0] resp_data  = '0;
    logic        late_ready = 1'b0;
    int          vcyc       = 0;

    // iomem responder: ready once valid has been high for resp_lat+1 cycles
    always @(negedge clk) begin
        if (iomem_valid === 1'b1) begin
            vcyc        = vcyc + 1;
            iomem_ready = !resp_never && (vcyc > resp_lat);
        end else begin
            vcyc        = 0;
            iomem_ready = late_ready;
        end
        iomem_rdata = resp_data;
    end

    // observation state (written only by the monitor)
    int          valid_cycles = 0;
    logic        prev_v       = 1'b0;
    int          stable_err   = 0;
    logic [31:0] last_addr    = '0;
    logic [31:0] last_wdata   = '0;
    logic [3:0]  last_wstrb   = '0;
    logic [7:0]  tx_log [0:255];
    int          tx_n         = 0;
    logic        hold_prev    = 1'b0;
    logic [7:0]  hold_data    = '0;
    int          hold_err     = 0;
    int          rx_acc       = 0;

    // monitor: bus cycle stability, response log, tx hold, rx acceptance count
    always @(negedge clk) begin
        if (iomem_valid === 1'b1) begin
            if (prev_v && ({iomem_addr, iomem_wdata, iomem_wstrb} !== {last_addr, last_wdata, last_wstrb}))
                stable_err = stable_err + 1;
            valid_cycles = valid_cycles + 1;
            last_addr    = iomem_addr;
            last_wdata   = iomem_wdata;
            last_wstrb   = iomem_wstrb;
        end
        prev_v = (iomem_valid === 1'b1);
        if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            tx_log[tx_n] = tx_data;
            tx_n = tx_n + 1;
        end
        if (hold_prev && (tx_valid !== 1'b1 || tx_data !== hold_data))
            hold_err = hold_err + 1;
        hold_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0);
        hold_data = tx_data;
        if (rx_valid === 1'b1 && rx_ready === 1'b1)
            rx_acc = rx_acc + 1;
    end

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [7:0] cmd_buf [0:8];
    int         cmd_len;

    task automatic send_cmd();
        for (int i = 0; i < cmd_len; i++) begin
            int w;
            rx_data  = cmd_buf[i];
            rx_valid = 1'b1;
            w = 0;
            @(negedge clk);
            while (!rx_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (rx_ready !== 1'b1) check("rx_stall", 32'(rx_ready), 32'(1));
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        do begin
            @(posedge clk);
            #1;
            w++;
        end while (busy && w < 300);
        check({tag, "_idle"}, 32'(busy), 32'(0));
    endtask

    task automatic check_rsp(input string tag, input int base, input int n, input logic [39:0] exp);
        check({tag, "_txcnt"}, 32'(tx_n - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < tx_n - base)
                check($sformatf("%s_tx%0d", tag, i), 32'(tx_log[base + i]), 32'(exp[39 - 8*i -: 8]));
        end
    endtask

    int base_v;
    int base_tx;
    int acc0;
    int h0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'(1));
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_iomem_valid", 32'(iomem_valid), 32'(0));
        check("rst_wstrb", 32'(iomem_wstrb), 32'(0));
        check("rst_addr", iomem_addr, 32'(0));
        check("rst_wdata", iomem_wdata, 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // full-word write, responder ready on second valid cycle
        base_v = valid_cycles; base_tx = tx_n;
        resp_lat = 1; resp_data = 32'hFFFF0000;
        cmd_buf = '{8'h8F, 8'h03, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        cmd_len = 9;
        send_cmd();
        check("wr_vrise", 32'(iomem_valid), 32'(1));
        check("wr_busy", 32'(busy), 32'(1));
        wait_idle("wr");
        check("wr_vcyc", 32'(valid_cycles - base_v), 32'(2));
        check("wr_addr", last_addr, 32'h03000000);
        check("wr_wdata", last_wdata, 32'hDEADBEEF);
        check("wr_wstrb", 32'(last_wstrb), 32'hF);
        check_rsp("wr", base_tx, 1, 40'h00_00000000);

        // read, unaligned address is word-aligned on the bus
        base_v = valid_cycles; base_tx = tx_n;
        resp_lat = 0; resp_data = 32'h12345678;
        cmd_buf = '{8'h00, 8'h03, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h00, 8'h00};
        cmd_len = 5;
        send_cmd();
        check("rd_vrise", 32'(iomem_valid), 32'(1));
        check("rd_rx_ready", 32'(rx_ready), 32'(0));
        wait_idle("rd");
        check("rd_vcyc", 32'(valid_cycles - base_v), 32'(1));
        check("rd_addr", last_addr, 32'h03000004);
        check("rd_wstrb", 32'(last_wstrb), 32'h0);
        check_rsp("rd", base_tx, 5, 40'h00_12345678);

        // write with zero strobes: no bus cycle, status 0x01
        base_v = valid_cycles; base_tx = tx_n;
        cmd_buf = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44};
        cmd_len = 9;
        send_cmd();
        check("ws0_novalid", 32'(iomem_valid), 32'(0));
        check("ws0_txv", 32'(tx_valid), 32'(1));
        wait_idle("ws0");
        check("ws0_vcyc", 32'(valid_cycles - base_v), 32'(0));
        check_rsp("ws0", base_tx, 1, 40'h01_00000000);

        // partial-strobe write, CMD bits 6:4 set and ignored
        base_v = valid_cycles; base_tx = tx_n;
        resp_lat = 0;
        cmd_buf = '{8'hF5, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h02, 8'h03, 8'h04};
        cmd_len = 9;
        send_cmd();
        wait_idle("wp");
        check("wp_vcyc", 32'(valid_cycles - base_v), 32'(1));
        check("wp_addr", last_addr, 32'h00000010);
        check("wp_wdata", last_wdata, 32'h01020304);
        check("wp_wstrb", 32'(last_wstrb), 32'h5);
        check_rsp("wp", base_tx, 1, 40'h00_00000000);

        // backpressure in RDAT with rx_valid held high
        base_tx = tx_n;
        resp_lat = 2; resp_data = 32'hA1B2C3D4;
        cmd_buf = '{8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        cmd_len = 5;
        send_cmd();
        for (int w = 0; w < 100 && (tx_n - base_tx) < 2; w++) begin
            @(posedge clk);
            #1;
        end
        check("bp_reach", 32'(tx_n - base_tx), 32'(2));
        tx_ready = 1'b0;
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        acc0 = rx_acc;
        h0   = hold_err;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("bp_rx_ready", 32'(rx_ready), 32'(0));
        check("bp_txv", 32'(tx_valid), 32'(1));
        check("bp_hold_data", 32'(tx_data), 32'hB2);
        check("bp_rxacc", 32'(rx_acc - acc0), 32'(0));
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wait_idle("bp");
        check("bp_hold", 32'(hold_err - h0), 32'(0));
        check_rsp("bp", base_tx, 5, 40'h00_A1B2C3D4);

        // reset during a stalled bus cycle, then a late ready
        base_tx = tx_n;
        resp_never = 1'b1;
        cmd_buf = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        cmd_len = 5;
        send_cmd();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rs_pre_valid", 32'(iomem_valid), 32'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rs_valid", 32'(iomem_valid), 32'(0));
        check("rs_busy", 32'(busy), 32'(0));
        check("rs_txv", 32'(tx_valid), 32'(0));
        reset = 1'b0;
        resp_never = 1'b0;
        late_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rs_late_busy", 32'(busy), 32'(0));
        check("rs_late_txv", 32'(tx_valid), 32'(0));
        check("rs_late_txn", 32'(tx_n - base_tx), 32'(0));
        late_ready = 1'b0;
        @(posedge clk);
        #1;
        resp_lat = 0; resp_data = 32'h0BADF00D;
        cmd_buf = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd();
        wait_idle("rs_rd");
        check("rs_rd_addr", last_addr, 32'h0000000C);
        check_rsp("rs_rd", base_tx, 5, 40'h00_0BADF00D);

`ifdef IOMEM_BRIDGE_TIMEOUT_EN
        // no ready at all: aborted after TMO+1 valid cycles
        base_v = valid_cycles; base_tx = tx_n;
        resp_never = 1'b1;
        cmd_buf = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd();
        wait_idle("to");
        check("to_vcyc", 32'(valid_cycles - base_v), 32'(TMO + 1));
        check_rsp("to", base_tx, 1, 40'hEE_00000000);
        resp_never = 1'b0;

        // ready on the very cycle the counter reaches the limit
        base_v = valid_cycles; base_tx = tx_n;
        resp_lat = TMO; resp_data = 32'h5A5AA5A5;
        send_cmd();
        wait_idle("tob");
        check("tob_vcyc", 32'(valid_cycles - base_v), 32'(TMO + 1));
        check_rsp("tob", base_tx, 5, 40'h00_5A5AA5A5);
`else
        // without the timeout the bus cycle waits indefinitely
        base_tx = tx_n;
        resp_never = 1'b1;
        cmd_buf = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd();
        repeat (30) begin
            @(posedge clk);
            #1;
        end
        check("nt_valid", 32'(iomem_valid), 32'(1));
        check("nt_busy", 32'(busy), 32'(1));
        resp_lat = 0; resp_data = 32'h5A5AA5A5;
        resp_never = 1'b0;
        wait_idle("nt");
        check_rsp("nt", base_tx, 5, 40'h00_5A5AA5A5);
`endif

        check("bus_stable", 32'(stable_err), 32'(0));
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
